// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-controller-side signals of the two-port SRAM arbiter.
// The arbiter uses the slave modport; requesters and the controller model sit on master.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              p0_rd_en;
    logic              p0_wr_en;
    logic [ADDR_W-1:0] p0_address;
    logic [31:0]       p0_wdata;
    logic [63:0]       p0_rdata;
    logic              p0_ready;
    logic              p1_rd_en;
    logic [ADDR_W-1:0] p1_address;
    logic [63:0]       p1_rdata;
    logic              p1_ready;
    logic              sram_rd_en;
    logic              sram_wr_en;
    logic [ADDR_W-1:0] sram_address;
    logic [31:0]       sram_wdata;
    logic [63:0]       sram_rdata;
    logic              sram_ready;
    logic              grant;
    logic              timeout_err;

    modport slave (
        input  p0_rd_en, p0_wr_en, p0_address, p0_wdata,
        input  p1_rd_en, p1_address,
        input  sram_rdata, sram_ready,
        output p0_rdata, p0_ready, p1_rdata, p1_ready,
        output sram_rd_en, sram_wr_en, sram_address, sram_wdata,
        output grant, timeout_err
    );

    modport master (
        output p0_rd_en, p0_wr_en, p0_address, p0_wdata,
        output p1_rd_en, p1_address,
        output sram_rdata, sram_ready,
        input  p0_rdata, p0_ready, p1_rdata, p1_ready,
        input  sram_rd_en, sram_wr_en, sram_address, sram_wdata,
        input  grant, timeout_err
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter between the data-cache port (0) and the fetch port (1) in front
// of a single SRAM controller, with a per-transaction watchdog.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              ptr_q, ptr_d;
    logic              kind_wr_q, kind_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              p0_ready_q, p0_ready_d;
    logic              p1_ready_q, p1_ready_d;
    logic              tmo_q, tmo_d;
    logic [63:0]       p0_rdata_q, p0_rdata_d;
    logic [63:0]       p1_rdata_q, p1_rdata_d;

    logic req0, req1, win, wr_sel;

    assign req0 = bus.p0_rd_en | bus.p0_wr_en;
    assign req1 = bus.p1_rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            ptr_q      <= 1'b0;
            kind_wr_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
            tmo_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            kind_wr_q  <= kind_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            p0_ready_q <= p0_ready_d;
            p1_ready_q <= p1_ready_d;
            tmo_q      <= tmo_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Enables and ready/abort pulses are computed one cycle ahead so every output is a flop.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        kind_wr_d  = kind_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        p0_ready_d = 1'b0;
        p1_ready_d = 1'b0;
        tmo_d      = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        win        = 1'b0;
        wr_sel     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win       = (req0 && req1) ? ptr_q : req1;
                    wr_sel    = !win && bus.p0_wr_en;
                    grant_d   = win;
                    kind_wr_d = wr_sel;
                    addr_d    = win ? bus.p1_address : bus.p0_address;
                    wdata_d   = win ? wdata_q : bus.p0_wdata;
                    cnt_d     = '0;
                    rd_en_d   = !wr_sel;
                    wr_en_d   = wr_sel;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cnt_d   = cnt_q + 1'b1;
                rd_en_d = !kind_wr_q;
                wr_en_d = kind_wr_q;
                // The controller's ready is still high from idle during the first BUSY cycle.
                if ((cnt_q != '0) && bus.sram_ready) begin
                    if (!kind_wr_q) begin
                        if (grant_q) p1_rdata_d = bus.sram_rdata;
                        else         p0_rdata_d = bus.sram_rdata;
                    end
                    rd_en_d    = 1'b0;
                    wr_en_d    = 1'b0;
                    p0_ready_d = !grant_q;
                    p1_ready_d = grant_q;
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_en_d    = 1'b0;
                    wr_en_d    = 1'b0;
                    p0_ready_d = !grant_q;
                    p1_ready_d = grant_q;
                    tmo_d      = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                ptr_d   = !grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sram_rd_en   = rd_en_q;
    assign bus.sram_wr_en   = wr_en_q;
    assign bus.sram_address = addr_q;
    assign bus.sram_wdata   = wdata_q;
    assign bus.p0_ready     = p0_ready_q;
    assign bus.p1_ready     = p1_ready_q;
    assign bus.p0_rdata     = p0_rdata_q;
    assign bus.p1_rdata     = p1_rdata_q;
    assign bus.grant        = grant_q;
    assign bus.timeout_err  = tmo_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter: a transaction-level model predicts
// each grant and its completion; a separate monitor pops and checks every ready pulse.
module tb_sram_port_arbiter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    sram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          port;
        bit          is_wr;
        bit          abort;
        int          busy_len;
        logic [63:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    bit          grant_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_rdata [2];

    bit          pend0, pend1, g0, g1, r0_wr, r0_rd;
    logic [31:0] a0, a1, d0;
    int          new_pct;
    bit          rand_lat;
    int          next_lat, cur_lat, busy_cyc;
    logic [63:0] next_rdata, cur_rdata;
    bit          en_prev, m_idle, m_done, m_ptr;
    bit          mon_on, mon_en_prev;
    int          busy_seen, pops;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.p0_rd_en   = pend0 & r0_rd;
        bus.p0_wr_en   = pend0 & r0_wr;
        bus.p0_address = a0;
        bus.p0_wdata   = d0;
        bus.p1_rd_en   = pend1;
        bus.p1_address = a1;
    endtask

    task automatic new_req0(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        pend0 = 1'b1; r0_wr = wr; r0_rd = rd; a0 = a; d0 = d;
    endtask

    task automatic new_req1(input logic [31:0] a);
        pend1 = 1'b1; a1 = a;
    endtask

    task automatic pick_next();
        if (rand_lat) begin
            next_lat   = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(2, TIMEOUT + 2));
            next_rdata = {$urandom, $urandom};
        end
    endtask

    // One clock of controller model, transaction-level arbitration model and requesters.
    task automatic step();
        bit   en_now, act_start, exp_start, win, idle_now;
        int   k;
        exp_t e;
        @(negedge clk);
        en_now    = bus.sram_rd_en | bus.sram_wr_en;
        act_start = en_now && !en_prev;
        exp_start = m_idle && (pend0 || pend1);

        if (act_start || exp_start) begin
            cur_lat   = next_lat;
            cur_rdata = next_rdata;
            busy_cyc  = 0;
            pick_next();
            chk("grant_taken", 64'(act_start), 64'(exp_start));
        end
        if (en_now) begin
            busy_cyc++;
            bus.sram_ready = (busy_cyc == 1) || (busy_cyc == cur_lat);
            bus.sram_rdata = (busy_cyc == cur_lat) ? cur_rdata : {$urandom, $urandom};
        end else begin
            bus.sram_ready = 1'b1;
            bus.sram_rdata = {$urandom, $urandom};
        end

        if (exp_start) begin
            win        = (pend0 && pend1) ? m_ptr : pend1;
            e.port     = win;
            e.is_wr    = !win && r0_wr;
            e.abort    = cur_lat > int'(TIMEOUT);
            e.busy_len = e.abort ? int'(TIMEOUT) : cur_lat;
            e.rdata    = cur_rdata;
            e.addr     = win ? a1 : a0;
            e.wdata    = d0;
            chk("grant", 64'(bus.grant), 64'(win));
            chk("start_addr", 64'(bus.sram_address), 64'(e.addr));
            chk("start_wr_en", 64'(bus.sram_wr_en), 64'(e.is_wr));
            if (e.is_wr) chk("start_wdata", 64'(bus.sram_wdata), 64'(e.wdata));
            sb_q.push_back(e);
            grant_log.push_back(bus.grant);
            m_ptr = !win;
            if (win) g1 = 1'b1; else g0 = 1'b1;
        end

        idle_now = m_done || (m_idle && !(pend0 || pend1));
        m_idle   = idle_now;
        m_done   = bus.p0_ready | bus.p1_ready;

        if (bus.p0_ready) begin
            pend0 = 1'b0; g0 = 1'b0;
        end else if (!pend0 && (int'($urandom_range(0, 99)) < new_pct)) begin
            k = int'($urandom_range(0, 7));
            new_req0(k <= 3, (k == 0) || (k > 3), $urandom, $urandom);
        end else if (g0 || !pend0) begin
            a0 = $urandom; d0 = $urandom;
        end
        if (bus.p1_ready) begin
            pend1 = 1'b0; g1 = 1'b0;
        end else if (!pend1 && (int'($urandom_range(0, 99)) < new_pct)) begin
            new_req1($urandom);
        end else if (g1 || !pend1) begin
            a1 = $urandom;
        end
        drive_reqs();
        en_prev = en_now;
    endtask

    task automatic run_quiet(input int max_cycles);
        bit quiet;
        quiet = 1'b0;
        for (int i = 0; i < max_cycles && !quiet; i++) begin
            step();
            quiet = !pend0 && !pend1 && (sb_q.size() == 0) && !en_prev && m_idle;
        end
        chk("drain", {61'd0, pend0, pend1, sb_q.size() != 0}, 64'd0);
    endtask

    task automatic reset_assert();
        mon_on = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_rd_en", 64'(bus.sram_rd_en), 64'd0);
        chk("rst_wr_en", 64'(bus.sram_wr_en), 64'd0);
        chk("rst_p0_ready", 64'(bus.p0_ready), 64'd0);
        chk("rst_p1_ready", 64'(bus.p1_ready), 64'd0);
        chk("rst_timeout", 64'(bus.timeout_err), 64'd0);
        chk("rst_p0_rdata", bus.p0_rdata, 64'd0);
        chk("rst_p1_rdata", bus.p1_rdata, 64'd0);
        chk("rst_addr", 64'(bus.sram_address), 64'd0);
        chk("rst_wdata", 64'(bus.sram_wdata), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        sb_q.delete();
        grant_log.delete();
        pend0 = 1'b0; pend1 = 1'b0; g0 = 1'b0; g1 = 1'b0;
        r0_wr = 1'b0; r0_rd = 1'b1; a0 = '0; a1 = '0; d0 = '0;
        m_idle = 1'b1; m_done = 1'b0; m_ptr = 1'b0;
        en_prev = 1'b0; busy_cyc = 0; mon_en_prev = 1'b0; busy_seen = 0; pops = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        bus.sram_ready = 1'b1;
        bus.sram_rdata = '0;
        drive_reqs();
    endtask

    task automatic reset_release();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_on = 1'b1;
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on each ready pulse.
    always @(negedge clk) begin
        bit   en;
        exp_t e;
        if (mon_on) begin
            en = bus.sram_rd_en | bus.sram_wr_en;
            if (en) chk("enable_onehot", 64'(bus.sram_rd_en & bus.sram_wr_en), 64'd0);
            if (en && mon_en_prev && sb_q.size() > 0) begin
                e = sb_q[0];
                chk("busy_addr", 64'(bus.sram_address), 64'(e.addr));
                chk("busy_wr_en", 64'(bus.sram_wr_en), 64'(e.is_wr));
                chk("busy_rd_en", 64'(bus.sram_rd_en), 64'(!e.is_wr));
                if (e.is_wr) chk("busy_wdata", 64'(bus.sram_wdata), 64'(e.wdata));
            end
            if (bus.timeout_err && !(bus.p0_ready || bus.p1_ready))
                chk("lone_timeout", 64'(bus.timeout_err), 64'd0);
            if (bus.p0_ready || bus.p1_ready) begin
                chk("ready_onehot", 64'(bus.p0_ready & bus.p1_ready), 64'd0);
                if (sb_q.size() != 1) begin
                    chk("sb_depth", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_port", 64'(bus.p1_ready), 64'(e.port));
                    chk("timeout_err", 64'(bus.timeout_err), 64'(e.abort));
                    chk("busy_cycles", 64'(busy_seen), 64'(e.busy_len));
                    if (!e.abort && !e.is_wr) exp_rdata[e.port] = e.rdata;
                    chk("p0_rdata", bus.p0_rdata, exp_rdata[0]);
                    chk("p1_rdata", bus.p1_rdata, exp_rdata[1]);
                    pops++;
                end
                busy_seen = 0;
            end
            if (en) busy_seen++;
            mon_en_prev = en;
        end
    end

    initial begin
        bit reached;
        mon_on = 1'b0; new_pct = 0; rand_lat = 1'b0;
        next_lat = 3; next_rdata = '0;
        reset_assert();
        reset_release();

        // Single read from port 1.
        next_lat = 5; next_rdata = 64'h1122_3344_5566_7788;
        new_req1(32'h40); drive_reqs();
        run_quiet(60);
        chk("single_p1_rdata", bus.p1_rdata, 64'h1122_3344_5566_7788);
        chk("single_p0_rdata", bus.p0_rdata, 64'd0);
        chk("single_grant", 64'(bus.grant), 64'd1);

        // Write from port 0.
        next_lat = 4;
        new_req0(1'b1, 1'b0, 32'h400, 32'hDEAD_BEEF); drive_reqs();
        run_quiet(60);
        chk("write_p0_rdata", bus.p0_rdata, 64'd0);

        // Contention from reset: both ports read continuously.
        reset_assert();
        reset_release();
        rand_lat = 1'b1; pick_next(); new_pct = 100;
        new_req0(1'b0, 1'b1, $urandom, $urandom); new_req1($urandom); drive_reqs();
        for (int i = 0; i < 400 && pops < 4; i++) step();
        new_pct = 0;
        run_quiet(200);
        chk("grant_log_len", 64'(grant_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("grant_order", 64'(grant_log[i]), 64'(i % 2));

        // Watchdog abort on port 0.
        rand_lat = 1'b0; next_lat = 40;
        new_req0(1'b0, 1'b1, 32'h80, 32'h0); drive_reqs();
        run_quiet(60);

        // Illegal read+write on port 0 performs a write.
        next_lat = 3;
        new_req0(1'b1, 1'b1, 32'h100, 32'h1234_5678); drive_reqs();
        run_quiet(60);

        // Randomized traffic.
        rand_lat = 1'b1; pick_next(); new_pct = 30;
        repeat (3000) step();
        new_pct = 0;
        run_quiet(300);

        // Reset during the third BUSY cycle of a port-0 read.
        rand_lat = 1'b0; next_lat = 40;
        new_req0(1'b0, 1'b1, 32'h1000, 32'h0); drive_reqs();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            reached = en_prev && (busy_cyc == 3);
        end
        chk("reached_busy3", 64'(reached), 64'd1);
        reset_assert();
        next_lat = 4; next_rdata = 64'hCAFE_F00D_0BAD_BEEF;
        new_req1(32'h2000); drive_reqs();
        reset_release();
        run_quiet(60);
        chk("post_rst_p1_rdata", bus.p1_rdata, 64'hCAFE_F00D_0BAD_BEEF);
        chk("post_rst_p0_rdata", bus.p0_rdata, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
